// File: rtl/gb_fb_write_ctrl_if.sv
// ---------------------------------------------------------------------------
// gb_fb_write_ctrl_if
// Bundles the PPU pixel stream, the framebuffer write port, the swap
// handshake with the VGA domain and the status outputs of gb_fb_write_ctrl.
//   master : pixel source / VGA side (drives LD, PX_VALID, LCD_ON,
//            FRAME_START, swap_ack; observes everything else)
//   slave  : gb_fb_write_ctrl itself
// ---------------------------------------------------------------------------
interface gb_fb_write_ctrl_if;
  logic [1:0]  LD;
  logic        PX_VALID;
  logic        LCD_ON;
  logic        FRAME_START;
  logic        swap_req;
  logic        swap_ack;
  logic        wr_en;
  logic [14:0] wr_addr;
  logic [1:0]  wr_data;
  logic        wr_bank;
  logic        disp_bank;
  logic [7:0]  frame_cnt;
  logic [7:0]  drop_cnt;
  logic        overrun;
  logic        short_frame;

  modport master (
    output LD, PX_VALID, LCD_ON, FRAME_START, swap_ack,
    input  swap_req, wr_en, wr_addr, wr_data, wr_bank, disp_bank,
           frame_cnt, drop_cnt, overrun, short_frame
  );

  modport slave (
    input  LD, PX_VALID, LCD_ON, FRAME_START, swap_ack,
    output swap_req, wr_en, wr_addr, wr_data, wr_bank, disp_bank,
           frame_cnt, drop_cnt, overrun, short_frame
  );
endinterface

// File: rtl/gb_fb_write_ctrl.sv
// ---------------------------------------------------------------------------
// gb_fb_write_ctrl
// Writes the Game Boy PPU pixel stream into one bank of a double-buffered
// framebuffer and hands completed frames to the VGA side with a toggle
// request / toggle acknowledge handshake.
//
// Ports:
//   GameBoy_clk    2^22 Hz Game Boy clock
//   GameBoy_reset  asynchronous, active-high reset
//   bus (slave)    LD/PX_VALID/LCD_ON/FRAME_START pixel input,
//                  wr_en/wr_addr/wr_data/wr_bank framebuffer write port,
//                  swap_req/swap_ack bank-swap handshake,
//                  disp_bank/frame_cnt/drop_cnt/overrun/short_frame status
//
// Optional feature macro: FB_BLANK_ON_LCD_OFF_EN
//   When defined, switching the LCD off clears the back buffer to shade 0
//   and swaps it in (BLANK state). When undefined the display keeps the
//   last completed frame.
// ---------------------------------------------------------------------------
module gb_fb_write_ctrl #(
  parameter int FB_W = 160,
  parameter int FB_H = 144
) (
  input logic              GameBoy_clk,
  input logic              GameBoy_reset,
  gb_fb_write_ctrl_if.slave bus
);

  localparam logic [14:0] LAST_IDX = 15'(FB_W * FB_H - 1);

`ifdef FB_BLANK_ON_LCD_OFF_EN
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SWAP_WAIT, S_BLANK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_SWAP_WAIT} state_t;
`endif

  state_t      r_state, w_state_nxt;
  logic [14:0] r_idx;
  logic        r_wr_en;
  logic [14:0] r_wr_addr;
  logic [1:0]  r_wr_data;
  logic        r_disp_bank;
  logic        r_swap_req;
  logic        r_ack_s1, r_ack_s2;
  logic [7:0]  r_frame_cnt;
  logic [7:0]  r_drop_cnt;
  logic        r_overrun;
  logic        r_short_frame;

  logic        w_wr_en;
  logic [14:0] w_wr_addr;
  logic [1:0]  w_wr_data;
  logic [14:0] w_idx_nxt;
  logic        w_toggle;
  logic        w_swap_done;
  logic        w_drop;
  logic        w_short;

  // A FRAME_START coinciding with a pixel places that pixel at address 0.
  logic [14:0] w_pix_addr;
  logic        w_last_px;
  logic        w_ack_done;

  assign w_pix_addr = bus.FRAME_START ? 15'd0 : r_idx;
  assign w_last_px  = bus.PX_VALID && (w_pix_addr == LAST_IDX);
  assign w_ack_done = (r_ack_s2 == r_swap_req);

  // State register
  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) r_state <= S_IDLE;
    else               r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.LCD_ON && bus.FRAME_START)
          w_state_nxt = w_last_px ? S_SWAP_WAIT : S_FILL;
      end
      S_FILL: begin
        if (!bus.LCD_ON)
`ifdef FB_BLANK_ON_LCD_OFF_EN
          w_state_nxt = S_BLANK;
`else
          w_state_nxt = S_IDLE;
`endif
        else if (w_last_px)
          w_state_nxt = S_SWAP_WAIT;
      end
      // Re-entering FILL at index 0 is what starts a frame whose
      // FRAME_START arrived while we were waiting for the VGA side.
      S_SWAP_WAIT: begin
        if (w_ack_done)
          w_state_nxt = bus.LCD_ON ? S_FILL : S_IDLE;
      end
`ifdef FB_BLANK_ON_LCD_OFF_EN
      S_BLANK: begin
        if (r_idx == LAST_IDX) w_state_nxt = S_SWAP_WAIT;
      end
`endif
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next-value logic
  always_comb begin
    w_wr_en     = 1'b0;
    w_wr_addr   = r_wr_addr;
    w_wr_data   = r_wr_data;
    w_idx_nxt   = r_idx;
    w_toggle    = 1'b0;
    w_swap_done = 1'b0;
    w_drop      = 1'b0;
    w_short     = 1'b0;
    case (r_state)
      S_IDLE, S_FILL: begin
        if (bus.LCD_ON && (bus.FRAME_START || r_state == S_FILL)) begin
          // Only a restart after real progress counts as a short frame.
          if (r_state == S_FILL && bus.FRAME_START && r_idx != 15'd0)
            w_short = 1'b1;
          w_idx_nxt = w_pix_addr;
          if (bus.PX_VALID) begin
            w_wr_en   = 1'b1;
            w_wr_addr = w_pix_addr;
            w_wr_data = bus.LD;
            if (w_last_px) begin
              w_idx_nxt = 15'd0;
              w_toggle  = 1'b1;
            end else begin
              w_idx_nxt = w_pix_addr + 15'd1;
            end
          end
        end else if (r_state == S_FILL) begin
          // LCD switched off: abandon the partial frame.
          w_idx_nxt = 15'd0;
        end
      end
      S_SWAP_WAIT: begin
        w_drop = bus.PX_VALID;
        if (w_ack_done) begin
          w_swap_done = 1'b1;
          w_idx_nxt   = 15'd0;
        end
      end
`ifdef FB_BLANK_ON_LCD_OFF_EN
      S_BLANK: begin
        w_wr_en   = 1'b1;
        w_wr_addr = r_idx;
        w_wr_data = 2'd0;
        if (r_idx == LAST_IDX) begin
          w_idx_nxt = 15'd0;
          w_toggle  = 1'b1;
        end else begin
          w_idx_nxt = r_idx + 15'd1;
        end
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge GameBoy_clk or posedge GameBoy_reset) begin
    if (GameBoy_reset) begin
      r_idx         <= 15'd0;
      r_wr_en       <= 1'b0;
      r_wr_addr     <= 15'd0;
      r_wr_data     <= 2'd0;
      r_disp_bank   <= 1'b0;
      r_swap_req    <= 1'b0;
      r_ack_s1      <= 1'b0;
      r_ack_s2      <= 1'b0;
      r_frame_cnt   <= 8'd0;
      r_drop_cnt    <= 8'd0;
      r_overrun     <= 1'b0;
      r_short_frame <= 1'b0;
    end else begin
      // Two-flop synchronizer for the VGA-domain acknowledge toggle
      r_ack_s1  <= bus.swap_ack;
      r_ack_s2  <= r_ack_s1;
      r_idx     <= w_idx_nxt;
      r_wr_en   <= w_wr_en;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
      if (w_toggle) r_swap_req <= ~r_swap_req;
      if (w_swap_done) begin
        r_disp_bank <= ~r_disp_bank;
        r_frame_cnt <= r_frame_cnt + 8'd1;
      end
      if (w_drop) begin
        r_overrun <= 1'b1;
        if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
      end
      if (w_short) r_short_frame <= 1'b1;
    end
  end

  assign bus.wr_en       = r_wr_en;
  assign bus.wr_addr     = r_wr_addr;
  assign bus.wr_data     = r_wr_data;
  assign bus.disp_bank   = r_disp_bank;
  assign bus.wr_bank     = ~r_disp_bank;
  assign bus.swap_req    = r_swap_req;
  assign bus.frame_cnt   = r_frame_cnt;
  assign bus.drop_cnt    = r_drop_cnt;
  assign bus.overrun     = r_overrun;
  assign bus.short_frame = r_short_frame;

endmodule

// File: tb/tb_gb_fb_write_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gb_fb_write_ctrl
// Directed stimulus for gb_fb_write_ctrl. Every pixel that should be
// written has its {addr, data} pushed into a queue; a monitor on the
// falling clock edge pops and compares whenever wr_en is high.
// ---------------------------------------------------------------------------
module tb_gb_fb_write_ctrl;

  localparam int FB_W = 160;
  localparam int FB_H = 144;
  localparam int NPIX = FB_W * FB_H;

  logic GameBoy_clk = 1'b0;
  logic GameBoy_reset;

  always #5 GameBoy_clk = ~GameBoy_clk;

  gb_fb_write_ctrl_if bus ();

  gb_fb_write_ctrl #(.FB_W(FB_W), .FB_H(FB_H)) dut (
    .GameBoy_clk   (GameBoy_clk),
    .GameBoy_reset (GameBoy_reset),
    .bus           (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [16:0] exp_q[$];

  task automatic chk(input string name, input int got, input int req);
    total++;
    if (got !== req) begin
      bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  task automatic push_wr(input int addr, input int data);
    logic [14:0] a;
    logic [1:0]  d;
    a = 15'(addr);
    d = 2'(data);
    exp_q.push_back({a, d});
  endtask

  task automatic drive(input logic pv, input logic [1:0] ld, input logic fs);
    bus.PX_VALID    = pv;
    bus.LD          = ld;
    bus.FRAME_START = fs;
    @(posedge GameBoy_clk);
    #1;
    bus.PX_VALID    = 1'b0;
    bus.FRAME_START = 1'b0;
  endtask

  task automatic tick();
    @(posedge GameBoy_clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge GameBoy_clk) begin
    logic [16:0] e;
    if (bus.wr_en === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got addr=%0d data=%0d required no write",
                 bus.wr_addr, bus.wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({bus.wr_addr, bus.wr_data} !== e) begin
          bad++;
          $display("FAIL write got addr=%0d data=%0d required addr=%0d data=%0d",
                   bus.wr_addr, bus.wr_data, e[16:2], e[1:0]);
        end
      end
    end
  end

  initial begin
    int k;
    bus.LD          = 2'd0;
    bus.PX_VALID    = 1'b0;
    bus.LCD_ON      = 1'b0;
    bus.FRAME_START = 1'b0;
    bus.swap_ack    = 1'b0;
    GameBoy_reset   = 1'b1;
    repeat (3) tick();

    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_wr_addr", bus.wr_addr, 0);
    chk("rst_wr_data", bus.wr_data, 0);
    chk("rst_disp_bank", bus.disp_bank, 0);
    chk("rst_wr_bank", bus.wr_bank, 1);
    chk("rst_swap_req", bus.swap_req, 0);
    chk("rst_frame_cnt", bus.frame_cnt, 0);
    chk("rst_drop_cnt", bus.drop_cnt, 0);
    chk("rst_overrun", bus.overrun, 0);
    chk("rst_short_frame", bus.short_frame, 0);

    GameBoy_reset = 1'b0;
    bus.LCD_ON    = 1'b1;
    tick();

    // Stray pixels in IDLE must be ignored
    repeat (3) drive(1'b1, 2'd3, 1'b0);

    // Full frame, LD = i%4, FRAME_START on the first pixel
    push_wr(0, 0);
    drive(1'b1, 2'd0, 1'b1);
    for (int i = 1; i < NPIX; i++) begin
      push_wr(i, i % 4);
      drive(1'b1, 2'(i % 4), 1'b0);
    end
    chk("frame_swap_req", bus.swap_req, 1);
    chk("frame_wr_bank", bus.wr_bank, 1);
    chk("frame_frame_cnt", bus.frame_cnt, 0);

    // Pixels during SWAP_WAIT are dropped (one carries a FRAME_START)
    for (int i = 0; i < 5; i++) drive(1'b1, 2'd1, (i == 2));
    chk("drop5_drop_cnt", bus.drop_cnt, 5);
    chk("drop5_overrun", bus.overrun, 1);
    chk("drop5_wr_bank", bus.wr_bank, 1);
    chk("drop5_queue_empty", exp_q.size(), 0);
    repeat (300) drive(1'b1, 2'd0, 1'b0);
    chk("drop_sat", bus.drop_cnt, 255);

    // Acknowledge toggle: bank swap must follow in 2-3 cycles
    bus.swap_ack = 1'b1;
    k = 0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      if (bus.disp_bank === 1'b1) begin
        k = c;
        break;
      end
    end
    if (k < 2 || k > 3) begin
      total++;
      bad++;
      $display("FAIL ack_latency got=%0d cycles required=2..3", k);
    end else begin
      total++;
    end
    chk("ack_disp_bank", bus.disp_bank, 1);
    chk("ack_wr_bank", bus.wr_bank, 0);
    chk("ack_frame_cnt", bus.frame_cnt, 1);

    // Back in FILL: 1000 pixels then an early FRAME_START with a pixel
    for (int i = 0; i < 1000; i++) begin
      push_wr(i, (i + 3) % 4);
      drive(1'b1, 2'((i + 3) % 4), 1'b0);
    end
    chk("pre_short_flag", bus.short_frame, 0);
    push_wr(0, 2);
    drive(1'b1, 2'd2, 1'b1);
    chk("short_flag", bus.short_frame, 1);
    chk("short_no_toggle", bus.swap_req, 1);

    // Pixels up to 500, then LCD off
    for (int i = 1; i < 500; i++) begin
      push_wr(i, (i + 1) % 4);
      drive(1'b1, 2'((i + 1) % 4), 1'b0);
    end
    bus.LCD_ON = 1'b0;
`ifdef FB_BLANK_ON_LCD_OFF_EN
    for (int a = 0; a < NPIX; a++) push_wr(a, 0);
`endif
    repeat (10) drive(1'b1, 2'd3, 1'b0);
`ifdef FB_BLANK_ON_LCD_OFF_EN
    k = 0;
    for (int c = 0; c < NPIX + 100; c++) begin
      if (bus.swap_req === 1'b0) begin
        k = 1;
        break;
      end
      tick();
    end
    chk("blank_toggle_seen", k, 1);
    chk("blank_swap_req", bus.swap_req, 0);
`else
    chk("lcdoff_swap_req", bus.swap_req, 1);
    // Second full frame to reach SWAP_WAIT again
    bus.LCD_ON = 1'b1;
    push_wr(0, 1);
    drive(1'b1, 2'd1, 1'b1);
    for (int i = 1; i < NPIX; i++) begin
      push_wr(i, (i + 1) % 4);
      drive(1'b1, 2'((i + 1) % 4), 1'b0);
    end
    chk("frame2_swap_req", bus.swap_req, 0);
    chk("frame2_frame_cnt", bus.frame_cnt, 1);
`endif
    tick();
    tick();
    chk("all_writes_seen", exp_q.size(), 0);

    // Asynchronous reset while waiting for the swap acknowledge
    @(posedge GameBoy_clk);
    #3;
    GameBoy_reset = 1'b1;
    bus.swap_ack  = 1'b0;
    #1;
    chk("arst_wr_en", bus.wr_en, 0);
    chk("arst_wr_addr", bus.wr_addr, 0);
    chk("arst_wr_data", bus.wr_data, 0);
    chk("arst_disp_bank", bus.disp_bank, 0);
    chk("arst_wr_bank", bus.wr_bank, 1);
    chk("arst_swap_req", bus.swap_req, 0);
    chk("arst_frame_cnt", bus.frame_cnt, 0);
    chk("arst_drop_cnt", bus.drop_cnt, 0);
    chk("arst_overrun", bus.overrun, 0);
    chk("arst_short_frame", bus.short_frame, 0);
    tick();
    GameBoy_reset = 1'b0;

    // A spurious acknowledge with no request outstanding changes nothing
    bus.swap_ack = 1'b1;
    repeat (6) tick();
    chk("spurious_ack_disp_bank", bus.disp_bank, 0);
    chk("spurious_ack_frame_cnt", bus.frame_cnt, 0);
    chk("spurious_ack_swap_req", bus.swap_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gb_fb_write_ctrl.md
GB_FB_WRITE_CTRL -- requirements
Module: gb_fb_write_ctrl

Interface
REQ-001 SHALL have parameter FB_W, default 160, Game Boy pixels per line.
REQ-002 SHALL have parameter FB_H, default 144, Game Boy lines per frame; FB_W*FB_H-1 SHALL fit in 15 bits.
REQ-003 SHALL have port GameBoy_clk  input  1  2^22 Hz Game Boy clock; reset GameBoy_reset, asynchronous, active-high; clock GameBoy_clk.
REQ-004 SHALL have port GameBoy_reset  input  1  asynchronous active-high reset.
REQ-005 SHALL have ports LD  input  2  pixel shade; PX_VALID  input  1  LD valid this cycle.
REQ-006 SHALL have ports LCD_ON  input  1  PPU LCD enable level; FRAME_START  input  1  one-cycle first-pixel-of-frame marker.
REQ-007 SHALL have ports swap_req  output  1  swap-request toggle; swap_ack  input  1  VGA-domain acknowledge toggle, asynchronous.
REQ-008 SHALL have ports wr_en  output  1; wr_addr  output  15; wr_data  output  2; wr_bank  output  1  framebuffer write port.
REQ-009 SHALL have ports disp_bank  output  1  bank being displayed; frame_cnt  output  8  completed swaps; drop_cnt  output  8  dropped pixels; overrun  output  1  sticky drop flag; short_frame  output  1  sticky early-restart flag.

Function
REQ-010 SHALL implement states IDLE, FILL, SWAP_WAIT, plus BLANK under REQ-025.
REQ-011 IDLE -> FILL when LCD_ON=1 and FRAME_START=1; any PX_VALID in IDLE other than on that cycle SHALL be ignored and not counted.
REQ-012 In FILL, each PX_VALID SHALL produce, one cycle later, wr_en=1 with wr_data=LD and wr_addr equal to the pixel index; wr_en=0 otherwise.
REQ-013 Pixel index SHALL start at 0 on FRAME_START and increment by 1 per accepted pixel (row-major, y*FB_W+x), with no multiplier.
REQ-014 FRAME_START with PX_VALID in the same cycle SHALL restart the index and write that pixel to address 0.
REQ-015 FRAME_START in FILL before index FB_W*FB_H-1 is written SHALL discard the partial frame (no swap), set short_frame, and restart at 0.
REQ-016 Writing index FB_W*FB_H-1 SHALL move to SWAP_WAIT and toggle swap_req on the same edge; the index SHALL wrap to 0.
REQ-017 swap_ack SHALL pass a two-flop synchronizer; swap completes when synchronized ack equals swap_req.
REQ-018 On swap completion: wr_bank and disp_bank invert, frame_cnt increments (255 -> 0 wrap), state -> FILL if LCD_ON=1 else IDLE.
REQ-019 In SWAP_WAIT, each PX_VALID SHALL be dropped: no write, drop_cnt += 1 saturating at 255, overrun set.
REQ-020 FRAME_START in SWAP_WAIT SHALL be latched and, on completion, start the next frame at index 0 in FILL.
REQ-021 LCD_ON falling in FILL SHALL abandon the frame -> IDLE (or BLANK per REQ-025); in SWAP_WAIT it SHALL take effect only after ack.
REQ-022 wr_bank SHALL always equal ~disp_bank.

Reset
REQ-023 On GameBoy_reset: state IDLE, index 0, wr_en 0, wr_addr 0, wr_data 0, disp_bank 0, wr_bank 1, swap_req 0, synchronizer flops 0, frame_cnt 0, drop_cnt 0, overrun 0, short_frame 0.
REQ-024 Reset asserted mid-frame or in SWAP_WAIT SHALL abort immediately with no further write or toggle; the VGA side SHALL be reset concurrently.

Configuration
REQ-025 With FB_BLANK_ON_LCD_OFF_EN defined: LCD_ON falling -> BLANK, write shade 0 to every address 0..FB_W*FB_H-1 at one per cycle, then toggle swap_req and enter SWAP_WAIT; LCD_ON rising with FRAME_START during BLANK SHALL be held until BLANK finishes. Without it: BLANK is absent and the display holds the last completed frame.

Verification
REQ-026 Reset, FRAME_START, then 23040 PX_VALID with LD=i%4 -> 23040 writes at addr 0..23039, swap_req 0->1, wr_bank stays 1 until ack.
REQ-027 Toggle swap_ack to 1 -> exactly 2-3 cycles later disp_bank=1, wr_bank=0, frame_cnt=1, state FILL.
REQ-028 5 PX_VALID during SWAP_WAIT -> no wr_en, drop_cnt=5, overrun=1; 300 more -> drop_cnt=255.
REQ-029 FRAME_START after 1000 pixels -> short_frame=1, no swap_req toggle, next pixel written to addr 0.
REQ-030 LCD_ON low at pixel 500 -> no further writes; with FB_BLANK_ON_LCD_OFF_EN: 23040 consecutive writes of data 0, then a swap_req toggle.
REQ-031 Assert GameBoy_reset in SWAP_WAIT -> all outputs at REQ-023 values asynchronously, and ack toggles are ignored until the next request.
